// File: rtl/ifetch_unit.sv
// ifetch_unit - instruction fetch stage in front of the single-cycle decode/execute core.
//
// Owns the program counter and issues word reads to instruction memory over a
// valid/ready request channel. Responses come back in order with no backpressure.
// Returned words are buffered in a FIFO and handed to decode as {code, pc, pc+4}.
// A redirect (taken branch/jump) flushes the buffer and marks every in-flight
// fetch as stale, so its response is discarded when it arrives.
//
// Parameters
//   RESET_PC         PC loaded on reset
//   FIFO_DEPTH       instruction buffer entries (power of 2, >= 2)
//   MAX_OUTSTANDING  max accepted-but-unanswered imem requests (1..FIFO_DEPTH)
//
// Ports
//   clk, rst         clock (posedge), asynchronous active-high reset
//   imem_req_*       fetch request: valid/ready, word-aligned byte address
//   imem_rsp_*       in-order response: valid, instruction word
//   inst_*           head of instruction buffer toward decode (valid/ready, code, pc, pc+4)
//   redirect*        branch/jump redirect strobe and target (bits [1:0] ignored)
//   fetch_stats      {fetched[15:0], discarded[15:0]}; present only when the
//                    IFETCH_STATS_EN macro is defined
//
// Optional feature macro: IFETCH_STATS_EN

module ifetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0] fetch_stats
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  // Architectural / pipeline state
  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_drop;

  // Instruction buffer storage (no reset; outputs are masked when empty)
  logic [31:0]   r_code_mem [FIFO_DEPTH];
  logic [31:0]   r_pc_mem   [FIFO_DEPTH];

  logic          w_req_fire;
  logic          w_rsp_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_drop_rsp;
  logic          w_req_ok;
  logic [31:0]   w_inflight;
  logic [31:0]   w_redir_pc;
  logic [OW-1:0] w_out_next;
  logic [CW-1:0] w_count_next;

  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

  // Buffer slots already claimed: stored words plus live (non-stale) fetches.
  // Stale fetches will be dropped, so they do not reserve a slot.
  assign w_inflight = 32'(r_count) + 32'(r_outstanding) - 32'(r_drop);
  assign w_req_ok   = (32'(r_outstanding) < MAX_OUTSTANDING) && (w_inflight < FIFO_DEPTH);

  assign imem_req_valid = !rst && w_req_ok;
  assign imem_req_addr  = rst ? '0 : r_pc;

  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_rsp_fire = imem_rsp_valid;
  assign w_pop      = inst_valid && inst_ready;

  // A response in the redirect cycle belongs to the old stream and is dropped too.
  assign w_drop_rsp = w_rsp_fire && ((r_drop != '0) || redirect);
  assign w_push     = w_rsp_fire && (r_drop == '0) && !redirect;

  always_comb begin
    w_out_next = r_outstanding;
    if (w_req_fire && !w_rsp_fire) begin
      w_out_next = r_outstanding + OW'(1);
    end else if (!w_req_fire && w_rsp_fire) begin
      w_out_next = r_outstanding - OW'(1);
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect) begin
        // Every fetch still in flight after this edge is stale. Requests are
        // sequential from the target, so the next kept response is for w_redir_pc.
        r_pc     <= w_redir_pc;
        r_rsp_pc <= w_redir_pc;
        r_drop   <= w_out_next;
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
      end else begin
        if (w_req_fire) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
          r_tail   <= r_tail + AW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + AW'(1);
        end
        r_count <= w_count_next;
        if (w_rsp_fire && (r_drop != '0)) begin
          r_drop <= r_drop - OW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_code_mem[r_tail] <= imem_rsp_data;
      r_pc_mem[r_tail]   <= r_rsp_pc;
    end
  end

  assign inst_valid = (r_count != '0);
  assign inst_code  = inst_valid ? r_code_mem[r_head] : '0;
  assign inst_pc    = inst_valid ? r_pc_mem[r_head] : '0;
  assign inst_pc4   = inst_valid ? (r_pc_mem[r_head] + 32'd4) : '0;

`ifdef IFETCH_STATS_EN
  logic [15:0] r_fetched;
  logic [15:0] r_discarded;
  logic [31:0] w_flushed;
  logic [31:0] w_disc_sum;

  // Entries popped in the redirect cycle were consumed by decode, not flushed.
  assign w_flushed  = redirect ? (32'(r_count) - 32'(w_pop)) : 32'd0;
  assign w_disc_sum = 32'(r_discarded) + 32'(w_drop_rsp) + w_flushed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetched   <= '0;
      r_discarded <= '0;
    end else begin
      if (w_push && (r_fetched != '1)) begin
        r_fetched <= r_fetched + 16'd1;
      end
      r_discarded <= (w_disc_sum > 32'h0000_FFFF) ? '1 : w_disc_sum[15:0];
    end
  end

  assign fetch_stats = {r_fetched, r_discarded};
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop_rsp;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_stats;
`endif

  ifetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .FIFO_DEPTH     (4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_code     (inst_code),
    .inst_pc       (inst_pc),
    .inst_pc4      (inst_pc4),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
`ifdef IFETCH_STATS_EN
    ,
    .fetch_stats   (fetch_stats)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] code;
    logic [31:0] pc4;
    int unsigned cyc;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  ent_t        log_q[$];
  req_t        mq[$];
  int unsigned lat    = 1;
  int unsigned n_edge = 0;
  int unsigned fires  = 0;
  int unsigned cyc    = 0;
  logic        tb_fired;
  int          n_cmp  = 0;
  int          n_fail = 0;
  int unsigned snap;

  always @(posedge clk) cyc <= cyc + 1;

  // Decode side: record every accepted instruction.
  always @(posedge clk) begin
    if (rst) log_q.delete();
    else if (inst_valid && inst_ready) log_q.push_back('{inst_pc, inst_code, inst_pc4, cyc});
  end

  // Instruction memory: fixed latency, in order, word = ~address.
  always @(posedge clk) begin
    tb_fired = imem_req_valid && imem_req_ready;
    n_edge++;
    if (rst) begin
      mq.delete();
      fires = 0;
    end else if (tb_fired) begin
      mq.push_back('{imem_req_addr, n_edge + lat - 1});
      fires++;
    end
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst && mq.size() > 0 && mq[0].due == n_edge) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mq[0].addr;
      void'(mq.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int unsigned l, input logic rdy);
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    inst_ready = rdy;
    imem_req_ready = 1'b1;
    lat = l;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 0);
    chk({tag, "_req_addr"}, imem_req_addr, 0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 0);
    chk({tag, "_inst_code"}, inst_code, 0);
    chk({tag, "_inst_pc"}, inst_pc, 0);
    chk({tag, "_inst_pc4"}, inst_pc4, 0);
`ifdef IFETCH_STATS_EN
    chk({tag, "_stats"}, fetch_stats, 0);
`endif
  endtask

  initial begin
    // ---- 1: reset state, then 1 inst/cycle with 1-cycle imem ----
    repeat (2) @(negedge clk);
    #1;
    chk_outputs_zero("t1_rst");
    inst_ready = 1'b1;
    lat = 1;
    rst = 1'b0;
    #1;
    chk("t1_first_req_valid", 32'(imem_req_valid), 1);
    chk("t1_first_req_addr", imem_req_addr, 32'h0);
    repeat (12) @(negedge clk);
    chk("t1_log_size", log_q.size(), 10);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("t1_pc", log_q[i].pc, 32'(i * 4));
      chk("t1_code", log_q[i].code, ~32'(i * 4));
      chk("t1_pc4", log_q[i].pc4, 32'(i * 4 + 4));
      if (i > 0) chk("t1_rate", log_q[i].cyc - log_q[i-1].cyc, 1);
    end
    // request held stable while imem stalls
    imem_req_ready = 1'b0;
    #1;
    chk("t1_hold_addr0", imem_req_addr, 32'h30);
    repeat (2) @(negedge clk);
    #1;
    chk("t1_hold_valid", 32'(imem_req_valid), 1);
    chk("t1_hold_addr2", imem_req_addr, 32'h30);
    imem_req_ready = 1'b1;

    // ---- 2: decode stalled, buffer fills to FIFO_DEPTH ----
    do_reset(1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("t2_head_early_valid", 32'(inst_valid), 1);
    chk("t2_head_early_pc", inst_pc, 32'h0);
    repeat (7) @(negedge clk);
    #1;
    chk("t2_fires", fires, 4);
    chk("t2_req_valid_low", 32'(imem_req_valid), 0);
    chk("t2_head_valid", 32'(inst_valid), 1);
    chk("t2_head_pc", inst_pc, 32'h0);
    chk("t2_head_code", inst_code, 32'hFFFF_FFFF);
    chk("t2_head_pc4", inst_pc4, 32'h4);
    inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("t2_log_size", 32'(log_q.size() >= 5), 1);
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      chk("t2_order_pc", log_q[i].pc, 32'(i * 4));
    end
    if (log_q.size() >= 4) chk("t2_drain_rate", log_q[3].cyc - log_q[0].cyc, 3);

    // ---- 3: 3-cycle imem, redirect with 2 outstanding ----
    do_reset(3, 1'b1);
    for (int k = 0; k < 20 && !(mq.size() == 2 && log_q.size() == 2); k++) @(negedge clk);
    chk("t3_sync", 32'(mq.size() == 2 && log_q.size() == 2), 1);
    #1;
    chk("t3_req_blocked", 32'(imem_req_valid), 0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("t3_still_blocked", 32'(imem_req_valid), 0);
    for (int k = 0; k < 40 && log_q.size() < 5; k++) @(negedge clk);
    chk("t3_progress", 32'(log_q.size() >= 5), 1);
    if (log_q.size() >= 5) begin
      chk("t3_first_pc", log_q[2].pc, 32'h100);
      chk("t3_first_code", log_q[2].code, ~32'h100);
      chk("t3_second_pc", log_q[3].pc, 32'h104);
      chk("t3_third_pc", log_q[4].pc, 32'h108);
    end

    // ---- 4: unaligned redirect target and PC wrap ----
    do_reset(1, 1'b1);
    repeat (5) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clk);
    redirect = 1'b0;
    snap = log_q.size();
    #1;
    chk("t4_req_valid", 32'(imem_req_valid), 1);
    chk("t4_req_addr", imem_req_addr, 32'h200);
    for (int k = 0; k < 10 && log_q.size() <= snap; k++) @(negedge clk);
    chk("t4_progress", 32'(log_q.size() > snap), 1);
    if (log_q.size() > snap) begin
      chk("t4_pc", log_q[snap].pc, 32'h200);
      chk("t4_code", log_q[snap].code, ~32'h200);
    end
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    snap = log_q.size();
    #1;
    chk("t4_wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    for (int k = 0; k < 10 && log_q.size() < snap + 2; k++) @(negedge clk);
    chk("t4_wrap_progress", 32'(log_q.size() >= snap + 2), 1);
    if (log_q.size() >= snap + 2) begin
      chk("t4_wrap_pc", log_q[snap].pc, 32'hFFFF_FFFC);
      chk("t4_wrap_pc4", log_q[snap].pc4, 32'h0);
      chk("t4_wrap_next_pc", log_q[snap+1].pc, 32'h0);
    end

    // ---- 5: redirect together with response and request fire ----
    do_reset(2, 1'b1);
    for (int k = 0; k < 10 && !(imem_rsp_valid && imem_req_valid); k++) @(negedge clk);
    chk("t5_sync", 32'(imem_rsp_valid && imem_req_valid), 1);
    redirect = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    snap = log_q.size();
    for (int k = 0; k < 30 && log_q.size() < snap + 3; k++) @(negedge clk);
    chk("t5_progress", 32'(log_q.size() >= snap + 3), 1);
    if (log_q.size() >= snap + 3) begin
      chk("t5_pc0", log_q[snap].pc, 32'h400);
      chk("t5_pc1", log_q[snap+1].pc, 32'h404);
      chk("t5_pc2", log_q[snap+2].pc, 32'h408);
      chk("t5_code0", log_q[snap].code, ~32'h400);
    end

    // ---- 6: reset in the middle of a burst ----
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_outputs_zero("t6_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_restart_valid", 32'(imem_req_valid), 1);
    chk("t6_restart_addr", imem_req_addr, 32'h0);
    for (int k = 0; k < 10 && log_q.size() < 1; k++) @(negedge clk);
    chk("t6_progress", 32'(log_q.size() >= 1), 1);
    if (log_q.size() >= 1) begin
      chk("t6_pc", log_q[0].pc, 32'h0);
      chk("t6_code", log_q[0].code, 32'hFFFF_FFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
